enc8to3_seq: RTL and testbench

ENC8TO3_SEQ -- requirements
Module: enc8to3_seq

---
 rtl/enc_pkg.sv | 21 ++
 rtl/pri_enc8.sv | 32 +++
 rtl/enc8to3_seq.sv | 118 +++++++++++
 tb/tb_enc8to3_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// enc_pkg: shared types and constants for the enc8to3_seq slice.
//   state_t   - controller state (IDLE: waiting for a vector, BUSY: emitting)
//   VEC_W     - request vector width
//   IDX_W     - encoded index width
//   is_single - true when a vector has exactly one bit set
package enc_pkg;

  localparam int VEC_W = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Clearing the lowest set bit leaves zero only for a one-hot vector.
  function automatic logic is_single(input logic [VEC_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/pri_enc8.sv
// pri_enc8: combinational 8-bit priority encoder.
//   PRIO_LSB - 1: report lowest set bit, 0: report highest set bit
//   in_vec   - input  [7:0] vector to encode
//   idx      - output [2:0] index of the winning bit (0 when in_vec is 0)
//   any      - output       at least one bit of in_vec is set
module pri_enc8
  import enc_pkg::*;
#(
  parameter bit PRIO_LSB = 1'b1
) (
  input  logic [VEC_W-1:0] in_vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = |in_vec;
    if (PRIO_LSB) begin
      // Scan downwards so the lowest set bit is the last one written.
      for (int i = VEC_W - 1; i >= 0; i--) begin
        if (in_vec[i]) idx = IDX_W'(i);
      end
    end else begin
      // Scan upwards so the highest set bit is the last one written.
      for (int i = 0; i < VEC_W; i++) begin
        if (in_vec[i]) idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/enc8to3_seq.sv
// enc8to3_seq: sequential 8-to-3 encoder. Accepts a multi-hot vector and
// emits the index of every set bit, one per out_valid/out_ready handshake.
//   PRIO_LSB  - 1: lowest set bit first, 0: highest set bit first
//   clk, rst  - clock (rising edge), asynchronous active-high reset
//   en        - capture enable, gates only the acceptance of new vectors
//   in_vec    - input  [7:0] request vector
//   in_valid  - input        in_vec is valid
//   in_ready  - output       vector accepted this cycle when in_valid is high
//   out_idx   - output [2:0] encoded index (registered)
//   out_valid - output       out_idx is valid (registered)
//   out_ready - input        downstream takes out_idx
//   out_last  - output       out_idx is the final set bit of the vector
//   zero_seen - output       one-cycle pulse after an all-zero vector is taken
module enc8to3_seq
  import enc_pkg::*;
#(
  parameter bit PRIO_LSB = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [VEC_W-1:0] in_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             zero_seen
);

  state_t             r_state;
  state_t             w_state_next;
  logic [VEC_W-1:0]   r_pending;
  logic [IDX_W-1:0]   r_out_idx;
  logic               r_out_valid;
  logic               r_out_last;
  logic               r_zero_seen;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_emit;
  logic [VEC_W-1:0]   w_pend_cleared;
  logic [VEC_W-1:0]   w_enc_src;
  logic [IDX_W-1:0]   w_enc_idx;
  logic               w_enc_any;

  assign w_in_ready = (r_state == IDLE) && en;
  assign w_accept   = in_valid && w_in_ready;
  assign w_emit     = r_out_valid && out_ready;

  // Pending with the bit currently on out_idx removed.
  assign w_pend_cleared = r_pending & ~(VEC_W'(1) << r_out_idx);

  // One encoder serves both cases: in IDLE it looks at the incoming vector
  // (first index), in BUSY at what remains after the current handshake.
  // Outputs are loaded one cycle ahead, so they stay purely registered.
  assign w_enc_src = (r_state == IDLE) ? in_vec : w_pend_cleared;

  pri_enc8 #(
    .PRIO_LSB(PRIO_LSB)
  ) u_pri_enc8 (
    .in_vec(w_enc_src),
    .idx   (w_enc_idx),
    .any   (w_enc_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_accept && w_enc_any) w_state_next = BUSY;
      BUSY: if (w_emit && r_out_last)  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending   <= '0;
      r_out_idx   <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_zero_seen <= 1'b0;
    end else begin
      r_zero_seen <= w_accept && !w_enc_any;
      if (r_state == IDLE) begin
        if (w_accept && w_enc_any) begin
          r_pending   <= in_vec;
          r_out_valid <= 1'b1;
          r_out_idx   <= w_enc_idx;
          r_out_last  <= is_single(in_vec);
        end
      end else if (w_emit) begin
        r_pending <= w_pend_cleared;
        if (r_out_last) begin
          r_out_valid <= 1'b0;
          r_out_idx   <= '0;
          r_out_last  <= 1'b0;
        end else begin
          r_out_idx  <= w_enc_idx;
          r_out_last <= is_single(w_pend_cleared);
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_idx   = r_out_idx;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign zero_seen = r_zero_seen;

endmodule

// File: tb/tb_enc8to3_seq.sv
// tb_enc8to3_seq: directed bench for enc8to3_seq. Two instances share the
// stimulus: u_dut (lowest bit first) and u_dut_msb (highest bit first).
module tb_enc8to3_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] in_vec = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, out_last, zero_seen;
  logic [2:0] out_idx;
  logic       m_in_ready, m_out_valid, m_out_last, m_zero_seen;
  logic [2:0] m_out_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  enc8to3_seq #(.PRIO_LSB(1'b1)) u_dut (
    .clk(clk), .rst(rst), .en(en), .in_vec(in_vec), .in_valid(in_valid),
    .in_ready(in_ready), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .zero_seen(zero_seen)
  );

  enc8to3_seq #(.PRIO_LSB(1'b0)) u_dut_msb (
    .clk(clk), .rst(rst), .en(en), .in_vec(in_vec), .in_valid(in_valid),
    .in_ready(m_in_ready), .out_idx(m_out_idx), .out_valid(m_out_valid),
    .out_ready(out_ready), .out_last(m_out_last), .zero_seen(m_zero_seen)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    #2;
    $display("reset: hold rst, en=1");
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", out_idx); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", out_last); end
    checks++; if (zero_seen !== 1'b0) begin errors++; $display("FAIL reset_zero got %b exp 0", zero_seen); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_en1 got %b exp 1", in_ready); end
    checks++; if (m_in_ready !== 1'b1 || m_zero_seen !== 1'b0) begin errors++; $display("FAIL reset_msb got rdy=%b zs=%b exp 1 0", m_in_ready, m_zero_seen); end
    en = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_en0 got %b exp 0", in_ready); end
    en = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    en = 1'b1; out_ready = 1'b1; in_vec = 8'b0000_0100; in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready0 got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    $display("single: beat idx=%0d last=%b", out_idx, out_last);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
    checks++; if (out_idx !== 3'd2) begin errors++; $display("FAIL single_idx got %0d exp 2", out_idx); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL single_last got %b exp 1", out_last); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_ready_busy got %b exp 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_done got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready2 got %b exp 1", in_ready); end
  endtask

  task automatic test_prio();
    logic [2:0] exp_lsb [3] = '{3'd0, 3'd2, 3'd7};
    logic [2:0] exp_msb [3] = '{3'd7, 3'd2, 3'd0};
    en = 1'b1; out_ready = 1'b1; in_vec = 8'b1000_0101; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      $display("prio: beat %0d lsb idx=%0d msb idx=%0d", b, out_idx, m_out_idx);
      checks++; if (out_valid !== 1'b1 || out_idx !== exp_lsb[b] || out_last !== (b == 2)) begin
        errors++; $display("FAIL prio_lsb beat %0d got v=%b idx=%0d last=%b exp 1 %0d %b", b, out_valid, out_idx, out_last, exp_lsb[b], (b == 2));
      end
      checks++; if (m_out_valid !== 1'b1 || m_out_idx !== exp_msb[b] || m_out_last !== (b == 2)) begin
        errors++; $display("FAIL prio_msb beat %0d got v=%b idx=%0d last=%b exp 1 %0d %b", b, m_out_valid, m_out_idx, m_out_last, exp_msb[b], (b == 2));
      end
      tick();
    end
    checks++; if (out_valid !== 1'b0 || m_out_valid !== 1'b0) begin errors++; $display("FAIL prio_done got %b %b exp 0 0", out_valid, m_out_valid); end
  endtask

  task automatic test_stall();
    en = 1'b1; out_ready = 1'b0; in_vec = 8'b0001_0010; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      $display("stall: cycle %0d idx=%0d", c, out_idx);
      checks++; if (out_valid !== 1'b1 || out_idx !== 3'd1 || out_last !== 1'b0) begin
        errors++; $display("FAIL stall_hold cyc %0d got v=%b idx=%0d last=%b exp 1 1 0", c, out_valid, out_idx, out_last);
      end
      tick();
    end
    out_ready = 1'b1;
    checks++; if (out_idx !== 3'd1 || out_last !== 1'b0) begin errors++; $display("FAIL stall_beat0 got idx=%0d last=%b exp 1 0", out_idx, out_last); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd4 || out_last !== 1'b1) begin errors++; $display("FAIL stall_beat1 got v=%b idx=%0d last=%b exp 1 4 1", out_valid, out_idx, out_last); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_done got %b exp 0", out_valid); end
  endtask

  task automatic test_en_zero();
    en = 1'b0; out_ready = 1'b1; in_vec = 8'h0F; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL en0_ready got %b exp 0", in_ready); end
    tick();
    tick();
    $display("en0: in_vec=0F offered with en=0");
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL en0_capture got %b exp 0", out_valid); end
    en = 1'b1; in_vec = 8'h00;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    $display("zero: in_vec=00 accepted zero_seen=%b", zero_seen);
    checks++; if (zero_seen !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL zero_pulse got zs=%b v=%b exp 1 0", zero_seen, out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_idle got %b exp 1", in_ready); end
    tick();
    checks++; if (zero_seen !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL zero_single got zs=%b v=%b exp 0 0", zero_seen, out_valid); end
  endtask

  task automatic test_all_ones();
    en = 1'b1; out_ready = 1'b1; in_vec = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    en = 1'b0; // must not disturb emission of the current vector
    for (int b = 0; b < 8; b++) begin
      $display("ones: beat %0d idx=%0d last=%b", b, out_idx, out_last);
      checks++; if (out_valid !== 1'b1 || out_idx !== 3'(b) || out_last !== (b == 7)) begin
        errors++; $display("FAIL ones beat %0d got v=%b idx=%0d last=%b exp 1 %0d %b", b, out_valid, out_idx, out_last, b, (b == 7));
      end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ones_done got %b exp 0", out_valid); end
    en = 1'b1;
  endtask

  task automatic test_rst_mid();
    en = 1'b1; out_ready = 1'b1; in_vec = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      $display("rstmid: beat %0d idx=%0d", b, out_idx);
      checks++; if (out_valid !== 1'b1 || out_idx !== 3'(b)) begin
        errors++; $display("FAIL rstmid beat %0d got v=%b idx=%0d exp 1 %0d", b, out_valid, out_idx, b);
      end
      tick();
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_idx !== 3'd0 || out_last !== 1'b0 || zero_seen !== 1'b0) begin
      errors++; $display("FAIL rstmid_async got v=%b idx=%0d last=%b zs=%b exp 0 0 0 0", out_valid, out_idx, out_last, zero_seen);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_idle got v=%b rdy=%b exp 0 1", out_valid, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_noresume got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    en = 1'b1; out_ready = 1'b1; in_vec = 8'h03; in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got %b exp 1", in_ready); end
    tick();
    in_vec = 8'h80;
    $display("b2b: beat idx=%0d", out_idx);
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL b2b_beat0 got v=%b idx=%0d rdy=%b exp 1 0 0", out_valid, out_idx, in_ready); end
    tick();
    $display("b2b: beat idx=%0d", out_idx);
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd1 || out_last !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL b2b_beat1 got v=%b idx=%0d last=%b rdy=%b exp 1 1 1 0", out_valid, out_idx, out_last, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_gap got v=%b rdy=%b exp 0 1", out_valid, in_ready); end
    tick();
    in_valid = 1'b0;
    $display("b2b: beat idx=%0d", out_idx);
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd7 || out_last !== 1'b1) begin errors++; $display("FAIL b2b_beat2 got v=%b idx=%0d last=%b exp 1 7 1", out_valid, out_idx, out_last); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_done got %b exp 0", out_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_prio();
    test_stall();
    test_en_zero();
    test_all_ones();
    test_rst_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
